// File: rtl/tx_controller.sv
// Sequencing FSM for the UART transmit datapath: accepts a byte on start/ready,
// then steps start, data, optional parity and stop bits, each held CLKS_PER_BIT clocks.
module tx_controller #(
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 1,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_start,
   input  logic       count_eq_size,
   output logic       tx_ready,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       reg_en,
   output logic       reset_reg,
   output logic       reset_count,
   output logic       count_en,
   output logic [1:0] mux2_sl
);

   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [BW-1:0]   r_baud;
   logic            r_stop;
   logic            w_bit_end;
   logic            w_stop_last;

   assign w_bit_end   = (r_baud == BAUD_LAST);
   assign w_stop_last = (STOP_BITS == 1) ? 1'b1 : r_stop;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Baud counter restarts on every state change and at each bit boundary within DATA/STOP
   always_ff @(posedge clk) begin
      if (reset) begin
         r_baud <= '0;
         r_stop <= 1'b0;
      end else begin
         if (r_state == S_IDLE || w_next != r_state || w_bit_end) begin
            r_baud <= '0;
         end else begin
            r_baud <= r_baud + {{(BW-1){1'b0}}, 1'b1};
         end
         if (r_state != S_STOP) begin
            r_stop <= 1'b0;
         end else if (w_bit_end) begin
            r_stop <= ~r_stop;
         end else begin
            r_stop <= r_stop;
         end
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (tx_start) w_next = S_START;
            else          w_next = S_IDLE;
         end
         S_START: begin
            if (w_bit_end) w_next = S_DATA;
            else           w_next = S_START;
         end
         S_DATA: begin
            if (w_bit_end && count_eq_size) w_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            else                            w_next = S_DATA;
         end
         S_PARITY: begin
            if (w_bit_end) w_next = S_STOP;
            else           w_next = S_PARITY;
         end
         S_STOP: begin
            if (w_bit_end && w_stop_last) w_next = S_IDLE;
            else                          w_next = S_STOP;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath controls and handshake outputs
   always_comb begin
      tx_ready    = 1'b0;
      tx_busy     = 1'b1;
      tx_done     = 1'b0;
      reg_en      = 1'b0;
      reset_count = 1'b1;
      count_en    = 1'b0;
      mux2_sl     = 2'd1;
      reset_reg   = ~reset;
      case (r_state)
         S_IDLE: begin
            tx_ready    = 1'b1;
            tx_busy     = 1'b0;
            reg_en      = tx_start & ~reset;
            reset_count = 1'b0;
            mux2_sl     = 2'd1;
         end
         S_START: begin
            reset_count = 1'b0;
            mux2_sl     = 2'd0;
         end
         S_DATA: begin
            mux2_sl  = 2'd2;
            count_en = w_bit_end & ~count_eq_size;
         end
         S_PARITY: begin
            mux2_sl = 2'd3;
         end
         S_STOP: begin
            mux2_sl = 2'd1;
            tx_done = w_bit_end & w_stop_last;
         end
         default: begin
            mux2_sl = 2'd1;
         end
      endcase
   end

endmodule

// File: tb/tb_tx_controller.sv
// Bench for tx_controller: two configurations, each driving a small datapath model,
// with the serial line checked against a frame model computed from the byte.
module tb_tx_controller;

   localparam int C  = 4;
   localparam int N  = 8;
   localparam int P0 = 1;
   localparam int S0 = 1;
   localparam int P1 = 0;
   localparam int S1 = 2;

   logic       clk;
   logic       reset;
   logic [1:0] start;
   logic [7:0] d_in;
   logic [1:0] eq;
   logic [1:0] rdy, busy, done, regen, rreg, rcnt, cen;
   logic [3:0] mux;

   logic [7:0] dreg [2];
   logic [2:0] dcnt [2];
   logic [1:0] line;

   int total = 0;
   int bad   = 0;

   tx_controller #(.CLKS_PER_BIT(C), .PARITY_EN(P0), .STOP_BITS(S0)) u0 (
      .clk(clk), .reset(reset), .tx_start(start[0]), .count_eq_size(eq[0]),
      .tx_ready(rdy[0]), .tx_busy(busy[0]), .tx_done(done[0]), .reg_en(regen[0]),
      .reset_reg(rreg[0]), .reset_count(rcnt[0]), .count_en(cen[0]), .mux2_sl(mux[1:0])
   );

   tx_controller #(.CLKS_PER_BIT(C), .PARITY_EN(P1), .STOP_BITS(S1)) u1 (
      .clk(clk), .reset(reset), .tx_start(start[1]), .count_eq_size(eq[1]),
      .tx_ready(rdy[1]), .tx_busy(busy[1]), .tx_done(done[1]), .reg_en(regen[1]),
      .reset_reg(rreg[1]), .reset_count(rcnt[1]), .count_en(cen[1]), .mux2_sl(mux[3:2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Datapath model: data register and bit counter driven by the controller
   always_ff @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (!rreg[k])      dreg[k] <= 8'h00;
         else if (regen[k]) dreg[k] <= d_in;
         if (!rcnt[k])      dcnt[k] <= 3'd0;
         else if (cen[k])   dcnt[k] <= dcnt[k] + 3'd1;
      end
   end

   always_comb begin
      line = 2'b00;
      eq   = 2'b00;
      for (int k = 0; k < 2; k++) begin
         eq[k] = (dcnt[k] == 3'd7);
         case (mux[2*k +: 2])
            2'd0:    line[k] = 1'b0;
            2'd1:    line[k] = 1'b1;
            2'd2:    line[k] = dreg[k][dcnt[k]];
            default: line[k] = ^dreg[k];
         endcase
      end
   end

   function automatic logic exp_line(input logic [7:0] b, input int t, input int p);
      int idx;
      idx = (t - 1) / C;
      if (idx == 0)                  return 1'b0;
      else if (idx <= N)             return b[idx-1];
      else if (p != 0 && idx == N+1) return ^b;
      else                           return 1'b1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic idle(input int k, input int ncyc);
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         start[k] = 1'b0;
         d_in = 8'($urandom);
         #1;
         chk("idle_ready", 32'(rdy[k]), 32'd1);
         chk("idle_busy",  32'(busy[k]), 32'd0);
         chk("idle_mux",   32'(mux[2*k +: 2]), 32'd1);
         chk("idle_done",  32'(done[k]), 32'd0);
         chk("idle_line",  32'(line[k]), 32'd1);
      end
   endtask

   // mode 0: single pulse, 1: extra ignored pulses at cycles 10 and 30, 2: tx_start held high
   task automatic frame(input int k, input logic [7:0] b, input int mode);
      int p, s, f, ce, m3;
      p  = (k == 0) ? P0 : P1;
      s  = (k == 0) ? S0 : S1;
      f  = C * (1 + N + p + s);
      ce = 0;
      m3 = 0;
      @(negedge clk);
      start[k] = 1'b1;
      d_in = b;
      #1;
      chk("acc_ready",  32'(rdy[k]), 32'd1);
      chk("acc_reg_en", 32'(regen[k]), 32'd1);
      for (int t = 1; t <= f; t++) begin
         @(negedge clk);
         start[k] = (mode == 2) || (mode == 1 && (t == 10 || t == 30));
         d_in = 8'($urandom);
         #1;
         chk("line",     32'(line[k]), 32'(exp_line(b, t, p)));
         chk("done",     32'(done[k]), 32'(t == f));
         chk("busy",     32'(busy[k]), 32'd1);
         chk("ready",    32'(rdy[k]), 32'd0);
         chk("reg_en",   32'(regen[k]), 32'd0);
         chk("count_en", 32'(cen[k]), 32'((t % C == 0) && (t / C >= 2) && (t / C <= N)));
         if (cen[k]) ce++;
         if (mux[2*k +: 2] == 2'd3) m3++;
      end
      chk("count_en_pulses", 32'(ce), 32'(N - 1));
      chk("parity_cycles",   32'(m3), 32'(p * C));
   endtask

   initial begin
      reset = 1'b1;
      start = 2'b00;
      d_in  = 8'h00;
      repeat (2) @(negedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("rst_ready",   32'(rdy[k]), 32'd1);
         chk("rst_busy",    32'(busy[k]), 32'd0);
         chk("rst_done",    32'(done[k]), 32'd0);
         chk("rst_reg_en",  32'(regen[k]), 32'd0);
         chk("rst_cen",     32'(cen[k]), 32'd0);
         chk("rst_mux",     32'(mux[2*k +: 2]), 32'd1);
         chk("rst_rcnt",    32'(rcnt[k]), 32'd0);
         chk("rst_rreg",    32'(rreg[k]), 32'd0);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rreg_release", 32'(rreg[0]), 32'd1);
      idle(0, 20);
      idle(1, 20);

      frame(0, 8'hA5, 0);
      idle(0, 2);
      frame(1, 8'hFF, 0);
      idle(1, 2);
      frame(0, 8'h3C, 1);
      idle(0, 1);
      frame(1, 8'($urandom), 1);
      idle(1, 1);

      frame(0, 8'($urandom), 2);
      frame(0, 8'($urandom), 2);
      frame(0, 8'($urandom), 0);
      idle(0, 1);
      frame(1, 8'($urandom), 2);
      frame(1, 8'($urandom), 0);
      idle(1, 1);

      // reset in the middle of DATA
      @(negedge clk);
      start[0] = 1'b1;
      d_in = 8'h5A;
      for (int t = 1; t <= 15; t++) begin
         @(negedge clk);
         start[0] = 1'b0;
         d_in = 8'($urandom);
      end
      #1;
      chk("mid_data_mux", 32'(mux[1:0]), 32'd2);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("mid_rst_rreg", 32'(rreg[0]), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("post_rst_mux",   32'(mux[1:0]), 32'd1);
      chk("post_rst_ready", 32'(rdy[0]), 32'd1);
      chk("post_rst_busy",  32'(busy[0]), 32'd0);
      chk("post_rst_rcnt",  32'(rcnt[0]), 32'd0);
      frame(0, 8'($urandom), 0);
      idle(0, 2);

      for (int i = 0; i < 3; i++) begin
         frame(i % 2, 8'($urandom), 0);
         idle(i % 2, 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
